uart_tx_cfg: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 `uart` transmit path. It serialises a parallel word onto `tx_output` with configurable data width, bit period and stop-bit count, and optional parity. It sits between a byte producer (CPU bridge or FIFO) and the board TX pin. It uses a ready/start handshake compatible with the existing `tx_start`/`tx_ready` usage.

---
 rtl/uart_tx_cfg_if.sv | 21 ++
 rtl/uart_tx_cfg.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Byte-in / serial-out handshake bundle for uart_tx_cfg; the producer holds the master side.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_ready;
  logic                 tx_sending;
  logic                 tx_output;
  logic                 tx_done;

  modport master (
    output tx_start, tx_byte,
    input  tx_ready, tx_sending, tx_output, tx_done
  );

  modport slave (
    input  tx_start, tx_byte,
    output tx_ready, tx_sending, tx_output, tx_done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter; parity bit built only with UART_TX_PARITY_EN. Line goes low the cycle after accept,
// frame takes F*CLKS_PER_BIT cycles; tx_start is only accepted in IDLE (tx_ready high), otherwise ignored.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic          tx_clk,
  input  logic          tx_rst,
  uart_tx_cfg_if.slave  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  // Parameter sanity window; any legal configuration leaves this branch unelaborated.
  if (PARITY_ODD < 0 || PARITY_ODD > 1 || STOP_BITS < 1 || STOP_BITS > 2 ||
      DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2) begin : g_cfg_out_of_range
  end

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_output_q, tx_output_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_sending_q, tx_sending_d;
  logic                 tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic last_baud;
  assign last_baud = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.tx_start) begin
          shift_d   = bus.tx_byte;
`ifdef UART_TX_PARITY_EN
          par_d     = (^bus.tx_byte) ^ PARITY_ODD[0];
`endif
          bit_cnt_d = '0;
          baud_d    = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (last_baud) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (last_baud) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (last_baud) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        // bit_cnt is reused to count stop bits
        if (last_baud) begin
          baud_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        baud_d    = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they line up with state_q.
  always_comb begin
    tx_output_d  = 1'b1;
    tx_ready_d   = 1'b0;
    tx_sending_d = 1'b1;
    tx_done_d    = 1'b0;
    case (state_d)
      S_IDLE: begin
        tx_ready_d   = 1'b1;
        tx_sending_d = 1'b0;
      end
      S_START:  tx_output_d = 1'b0;
      S_DATA:   tx_output_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_output_d = par_d;
`endif
      S_STOP: begin
        tx_output_d = 1'b1;
        tx_done_d   = (baud_d == BAUD_LAST) && (bit_cnt_d == STOP_LAST);
      end
      default: tx_output_d = 1'b1;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_output_q  <= 1'b1;
      tx_ready_q   <= 1'b1;
      tx_sending_q <= 1'b0;
      tx_done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_output_q  <= tx_output_d;
      tx_ready_q   <= tx_ready_d;
      tx_sending_q <= tx_sending_d;
      tx_done_q    <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign bus.tx_output  = tx_output_q;
  assign bus.tx_ready   = tx_ready_q;
  assign bus.tx_sending = tx_sending_q;
  assign bus.tx_done    = tx_done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8-bit/1-stop and 5-bit/2-stop instances at 4 clocks per bit.
module tb_uart_tx_cfg;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic tx_clk = 1'b0;
  logic tx_rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 tx_clk = ~tx_clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) ifa ();
  uart_tx_cfg_if #(.DATA_BITS(5)) ifb ();

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .tx_clk (tx_clk),
    .tx_rst (tx_rst),
    .bus    (ifa.slave)
  );

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .tx_clk (tx_clk),
    .tx_rst (tx_rst),
    .bus    (ifb.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input int sel, input logic start, input logic [8:0] b);
    if (sel == 0) begin
      ifa.tx_start = start;
      ifa.tx_byte  = b[7:0];
    end else begin
      ifb.tx_start = start;
      ifb.tx_byte  = b[4:0];
    end
  endtask

  // Expected line level for frame bit idx: start, data LSB first, optional parity, stop(s).
  function automatic logic exp_bit(input int idx, input logic [8:0] b, input int nbits, input logic podd);
    logic par;
    par = podd;
    for (int i = 0; i < nbits; i++) par = par ^ b[i];
    if (idx == 0) return 1'b0;
    if (idx <= nbits) return b[idx-1];
    if (P == 1 && idx == nbits + 1) return par;
    return 1'b1;
  endfunction

  task automatic check_idle(input int sel, input string tag);
    check({tag, "_out"},     sel ? ifb.tx_output  : ifa.tx_output,  1);
    check({tag, "_ready"},   sel ? ifb.tx_ready   : ifa.tx_ready,   1);
    check({tag, "_sending"}, sel ? ifb.tx_sending : ifa.tx_sending, 0);
    check({tag, "_done"},    sel ? ifb.tx_done    : ifa.tx_done,    0);
  endtask

  // Called with tx_start already high; the first edge is the accept edge.
  task automatic check_frame(input int sel, input logic [8:0] b, input logic hold, input logic [8:0] mid_b,
                             input string tag);
    int   nb, fc;
    logic podd;
    nb   = sel ? 5 : 8;
    podd = sel ? 1'b1 : 1'b0;
    fc   = (1 + nb + P + (sel ? 2 : 1)) * CPB;
    for (int k = 1; k <= fc; k++) begin
      @(posedge tx_clk); #1;
      if (k == 1)  drive(sel, hold, b);
      if (k == 10) drive(sel, hold, mid_b);
      check($sformatf("%s_out_c%0d", tag, k), sel ? ifb.tx_output : ifa.tx_output,
            exp_bit((k - 1) / CPB, b, nb, podd));
      check($sformatf("%s_done_c%0d", tag, k), sel ? ifb.tx_done : ifa.tx_done, (k == fc));
      check($sformatf("%s_ready_c%0d", tag, k), sel ? ifb.tx_ready : ifa.tx_ready, 0);
      check($sformatf("%s_sending_c%0d", tag, k), sel ? ifb.tx_sending : ifa.tx_sending, 1);
    end
    @(posedge tx_clk); #1;
    check_idle(sel, {tag, "_after"});
  endtask

  initial begin
    drive(0, 1'b0, 9'h000);
    drive(1, 1'b0, 9'h000);

    for (int i = 0; i < 3; i++) begin
      @(posedge tx_clk); #1;
      check_idle(0, $sformatf("rst%0d_a", i));
      check_idle(1, $sformatf("rst%0d_b", i));
    end
    tx_rst = 1'b0;
    @(posedge tx_clk); #1;
    check_idle(0, "post_rst_a");

    // Single 0xBE frame: 0,0,1,1,1,1,1,0,1,1 (plus parity when built)
    drive(0, 1'b1, 9'h0BE);
    check_frame(0, 9'h0BE, 1'b0, 9'h0BE, "f8n1");

    // Held start: byte changes mid-frame, one idle gap, then 0x55
    drive(0, 1'b1, 9'h0BE);
    check_frame(0, 9'h0BE, 1'b1, 9'h055, "held1");
    check_frame(0, 9'h055, 1'b0, 9'h055, "held2");

    // Reset during data bit 3 drops the frame
    drive(0, 1'b1, 9'h0BE);
    for (int k = 1; k <= 4 * CPB + 2; k++) begin
      @(posedge tx_clk); #1;
      if (k == 1) drive(0, 1'b0, 9'h0BE);
    end
    check("midrst_pre_out", ifa.tx_output, 1);
    tx_rst = 1'b1;
    @(posedge tx_clk); #1;
    check_idle(0, "midrst");
    tx_rst = 1'b0;
    drive(0, 1'b1, 9'h00F);
    check_frame(0, 9'h00F, 1'b0, 9'h00F, "after_rst");

    // 5 data bits, 2 stop bits
    drive(1, 1'b1, 9'h01F);
    check_frame(1, 9'h01F, 1'b0, 9'h01F, "w5s2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
